// File: rtl/key_sw_device_pkg.sv
// Shared constants for the KEY/SW memory-mapped responder: default addresses,
// control-register bit positions and input group widths.
package key_sw_device_pkg;

  localparam logic [31:0] DEF_ADDR_KEY   = 32'hF000_0010;
  localparam logic [31:0] DEF_ADDR_KCTRL = 32'hF000_0110;
  localparam logic [31:0] DEF_ADDR_SW    = 32'hF000_0014;
  localparam logic [31:0] DEF_ADDR_SCTRL = 32'hF000_0114;

  localparam int CTRL_READY = 0;
  localparam int CTRL_OVR   = 2;
  localparam int CTRL_IE    = 4;

  localparam int KEY_W = 4;
  localparam int SW_W  = 10;

  // Control register image; unused bits read as zero.
  function automatic logic [31:0] ctrl_word(input logic ready, input logic ovr, input logic ie);
    logic [31:0] w;
    w             = '0;
    w[CTRL_READY] = ready;
    w[CTRL_OVR]   = ovr;
    w[CTRL_IE]    = ie;
    return w;
  endfunction

endpackage

// File: rtl/key_sw_device_input_status_reg.sv
// One input group's data register plus its READY/OVERRUN/IE status, with
// change detection, read-to-clear and control-register writes.
module input_status_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         upd_en,
  input  logic [W-1:0] new_data,
  input  logic         rd_clr,
  input  logic         ctrl_wr,
  input  logic         wr_ie,
  input  logic         wr_ovr,
  output logic [W-1:0] data,
  output logic         ready,
  output logic         ovr,
  output logic         ie
);

  logic [W-1:0] data_q, data_d;
  logic         ready_q, ready_d;
  logic         ovr_q, ovr_d;
  logic         ie_q, ie_d;
  logic         chg;

  always_comb begin
    chg     = upd_en && (new_data != data_q);
    data_d  = chg ? new_data : data_q;
    ready_d = chg ? 1'b1 : (rd_clr ? 1'b0 : ready_q);
    ie_d    = ctrl_wr ? wr_ie : ie_q;
    ovr_d   = ovr_q;
    if (ctrl_wr && !wr_ovr) ovr_d = 1'b0;
    // A read on the same edge consumes the old value, so nothing is lost.
    if (chg && ready_q && !rd_clr) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      data_q  <= data_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      ie_q    <= ie_d;
    end
  end

  assign data  = data_q;
  assign ready = ready_q;
  assign ovr   = ovr_q;
  assign ie    = ie_q;

endmodule

// File: rtl/key_sw_device.sv
// Memory-mapped KEY/SW responder: synchronizes raw inputs, debounces SW,
// and exposes data/control registers with combinational read data and irq.
module key_sw_device
  import key_sw_device_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_KEY        = DBITS'(DEF_ADDR_KEY),
  parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(DEF_ADDR_KCTRL),
  parameter logic [DBITS-1:0] ADDR_SW         = DBITS'(DEF_ADDR_SW),
  parameter logic [DBITS-1:0] ADDR_SCTRL      = DBITS'(DEF_ADDR_SCTRL),
  parameter int               DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wrt_data,
  input  logic             wrt_en,
  input  logic             rd_en,
  output logic [DBITS-1:0] rd_data,
  output logic             hit,
  input  logic [KEY_W-1:0] KEY,
  input  logic [SW_W-1:0]  SW,
  output logic             irq
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [KEY_W-1:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [SW_W-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic hit_key, hit_kctrl, hit_sw, hit_sctrl;
  logic [KEY_W-1:0] kdata;
  logic [SW_W-1:0]  sdata;
  logic kready, kovr, kie, sready, sovr, sie;

  always_comb begin
    key_s1_d = ~KEY;
    key_s2_d = key_s1_q;
    sw_s1_d  = SW;
    sw_s2_d  = sw_s1_q;
    // Any movement between the sync stages restarts the stability window.
    if (sw_s1_q != sw_s2_q)   cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      cnt_q    <= '0;
    end else begin
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hit_key   = (addr == ADDR_KEY);
  assign hit_kctrl = (addr == ADDR_KCTRL);
  assign hit_sw    = (addr == ADDR_SW);
  assign hit_sctrl = (addr == ADDR_SCTRL);
  assign hit       = hit_key | hit_kctrl | hit_sw | hit_sctrl;

  input_status_reg #(.W(KEY_W)) u_key (
    .clk      (clk),
    .reset_n  (reset_n),
    .upd_en   (1'b1),
    .new_data (key_s2_q),
    .rd_clr   (rd_en & hit_key),
    .ctrl_wr  (wrt_en & hit_kctrl),
    .wr_ie    (wrt_data[CTRL_IE]),
    .wr_ovr   (wrt_data[CTRL_OVR]),
    .data     (kdata),
    .ready    (kready),
    .ovr      (kovr),
    .ie       (kie)
  );

  input_status_reg #(.W(SW_W)) u_sw (
    .clk      (clk),
    .reset_n  (reset_n),
    .upd_en   (cnt_q == CNT_MAX),
    .new_data (sw_s2_q),
    .rd_clr   (rd_en & hit_sw),
    .ctrl_wr  (wrt_en & hit_sctrl),
    .wr_ie    (wrt_data[CTRL_IE]),
    .wr_ovr   (wrt_data[CTRL_OVR]),
    .data     (sdata),
    .ready    (sready),
    .ovr      (sovr),
    .ie       (sie)
  );

  always_comb begin
    rd_data = '0;
    if (hit_key)        rd_data = DBITS'(kdata);
    else if (hit_kctrl) rd_data = DBITS'(ctrl_word(kready, kovr, kie));
    else if (hit_sw)    rd_data = DBITS'(sdata);
    else if (hit_sctrl) rd_data = DBITS'(ctrl_word(sready, sovr, sie));
  end

  assign irq = (kie & kready) | (sie & sready);

endmodule

// File: tb/tb_key_sw_device.sv
// Directed bench for key_sw_device with a short debounce interval.
module tb_key_sw_device;

  localparam logic [31:0] A_KEY   = 32'hF000_0010;
  localparam logic [31:0] A_KCTRL = 32'hF000_0110;
  localparam logic [31:0] A_SW    = 32'hF000_0014;
  localparam logic [31:0] A_SCTRL = 32'hF000_0114;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr, wrt_data, rd_data;
  logic        wrt_en, rd_en, hit, irq;
  logic [3:0]  KEY;
  logic [9:0]  SW;

  int errors = 0;
  int checks = 0;

  key_sw_device #(.DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wrt_data(wrt_data),
    .wrt_en(wrt_en), .rd_en(rd_en), .rd_data(rd_data), .hit(hit),
    .KEY(KEY), .SW(SW), .irq(irq)
  );

  always #10 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; rd_en = 1'b0; wrt_en = 1'b0;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wrt_data = d; wrt_en = 1'b1;
    step(1);
    wrt_en = 1'b0;
  endtask

  task automatic load_clr(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; rd_en = 1'b1;
    #1;
    chk(tag, rd_data, exp);
    step(1);
    rd_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; addr = '0; wrt_data = '0; wrt_en = 1'b0; rd_en = 1'b0;
    KEY = 4'hF; SW = 10'h000;
    step(3);
    chk_reg("rst_kdata", A_KEY, 32'h0);
    chk_reg("rst_kctrl", A_KCTRL, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    step(12);

    // Key press: visible on the third edge, not before
    KEY = 4'hD;
    step(2);
    chk_reg("key_lat2_kdata", A_KEY, 32'h0);
    step(1);
    chk_reg("key_press_kdata", A_KEY, 32'h2);
    chk_reg("key_press_kctrl", A_KCTRL, 32'h1);
    chk("key_hit", {31'b0, hit}, 32'h1);

    // Second change without a read -> overrun
    KEY = 4'h9;
    step(3);
    chk_reg("key2_kdata", A_KEY, 32'h6);
    chk_reg("key2_kctrl_ovr", A_KCTRL, 32'h5);
    chk("key2_irq_ie0", {31'b0, irq}, 32'h0);
    store(A_KCTRL, 32'h0);
    chk_reg("kctrl_ovr_clr", A_KCTRL, 32'h1);
    load_clr("kdata_read", A_KEY, 32'h6);
    chk_reg("kctrl_after_read", A_KCTRL, 32'h0);

    // Read on the same edge as a change: old data returned, event wins
    KEY = 4'hF;
    step(2);
    load_clr("kread_same_edge_old", A_KEY, 32'h6);
    chk_reg("kdata_same_edge_new", A_KEY, 32'h0);
    chk_reg("kctrl_same_edge", A_KCTRL, 32'h1);
    load_clr("kdata_clear2", A_KEY, 32'h0);
    chk_reg("kctrl_clear2", A_KCTRL, 32'h0);

    // SW glitch shorter than the debounce window is never reported
    SW = 10'h001;
    step(3);
    SW = 10'h000;
    step(15);
    chk_reg("sw_glitch_sdata", A_SW, 32'h0);
    chk_reg("sw_glitch_sctrl", A_SCTRL, 32'h0);

    store(A_SCTRL, 32'h10);
    chk_reg("sctrl_ie", A_SCTRL, 32'h10);
    chk("irq_ie_only", {31'b0, irq}, 32'h0);

    // Stable SW reported exactly 11 edges after the raw change
    SW = 10'h3FF;
    step(10);
    chk_reg("sw_edge10_sdata", A_SW, 32'h0);
    chk("sw_edge10_irq", {31'b0, irq}, 32'h0);
    step(1);
    chk_reg("sw_edge11_sdata", A_SW, 32'h3FF);
    chk_reg("sw_edge11_sctrl", A_SCTRL, 32'h11);
    chk("sw_irq_rise", {31'b0, irq}, 32'h1);
    load_clr("sdata_read", A_SW, 32'h3FF);
    chk("sw_irq_fall", {31'b0, irq}, 32'h0);
    chk_reg("sctrl_after_read", A_SCTRL, 32'h10);

    // Async reset mid-count with READY pending and irq high
    store(A_KCTRL, 32'h10);
    SW = 10'h000; KEY = 4'hE;
    step(5);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    chk_reg("pre_rst_kctrl", A_KCTRL, 32'h11);
    reset_n = 1'b0;
    chk_reg("arst_kdata", A_KEY, 32'h0);
    chk_reg("arst_kctrl", A_KCTRL, 32'h0);
    chk_reg("arst_sdata", A_SW, 32'h0);
    chk_reg("arst_sctrl", A_SCTRL, 32'h0);
    chk("arst_irq", {31'b0, irq}, 32'h0);
    KEY = 4'hF;
    step(2);
    reset_n = 1'b1;
    step(14);
    chk_reg("post_rst_sdata", A_SW, 32'h0);

    // Stores to the data address are ignored
    KEY = 4'h7;
    step(3);
    chk_reg("kdata_before_store", A_KEY, 32'h8);
    store(A_KEY, 32'h3);
    chk_reg("kdata_store_ignored", A_KEY, 32'h8);

    // Unmapped address
    addr = 32'hF000_0018;
    #1;
    chk("unmapped_hit", {31'b0, hit}, 32'h0);
    chk("unmapped_rd", rd_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
